// File: rtl/onehot_led_display_if.sv
// Step-vector and display bundle between the step timer / board pins and the
// one-hot decoder.
//   onehot_in  : step vector from the timer (bit k set = step k)
//   idx_out    : registered step index
//   idx_valid  : registered vector was exactly one-hot
//   err_sticky : a non-one-hot vector has been seen since reset
//   led_en     : digit enables, active-low
//   led_seg    : segments, active-low, {dp,g,f,e,d,c,b,a}
interface onehot_led_display_if #(
  parameter int unsigned WIDTH  = 21,
  parameter int unsigned DIGITS = 8
);
  logic [WIDTH-1:0]  onehot_in;
  logic [4:0]        idx_out;
  logic              idx_valid;
  logic              err_sticky;
  logic [DIGITS-1:0] led_en;
  logic [7:0]        led_seg;

  // Driver side: timer and display observer.
  modport master (
    output onehot_in,
    input  idx_out, idx_valid, err_sticky, led_en, led_seg
  );

  // Decoder side.
  modport slave (
    input  onehot_in,
    output idx_out, idx_valid, err_sticky, led_en, led_seg
  );
endinterface

// File: rtl/onehot_led_display.sv
// One-hot step decoder with an 8-digit multiplexed common-anode display.
// Registers the step vector, encodes it to an index (flagging non-one-hot
// vectors), and scans the index as two decimal digits ("--" when invalid);
// the last digit's decimal point shows the sticky error flag.
//   clk  : system clock
//   rst  : asynchronous, active-low reset
//   bus  : onehot_led_display_if.slave (vector in, index/status/display out)
module onehot_led_display #(
  parameter int unsigned WIDTH    = 21,
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned SCAN_DIV = 200000
) (
  input  logic                  clk,
  input  logic                  rst,
  onehot_led_display_if.slave   bus
);

  localparam int unsigned IDX_W = 5;
  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_DP    = 8'h7F;

  logic [WIDTH-1:0]  in_q;
  logic              in_vld;     // in_q holds a real sample, not its reset value
  logic [IDX_W-1:0]  idx_q;
  logic              valid_q;
  logic              err_q;
  logic [CNT_W-1:0]  scan_cnt;
  logic [PTR_W-1:0]  ptr;
  logic [DIGITS-1:0] en_q;
  logic [7:0]        seg_q;

  logic [IDX_W-1:0]  enc_idx;
  logic [1:0]        enc_cnt;    // saturating set-bit count: 0, 1, or 2+
  logic              enc_onehot;
  logic [3:0]        tens;
  logic [3:0]        ones;
  logic [DIGITS-1:0] en_d;
  logic [7:0]        seg_d;

  // Active-low 7-segment glyph for a decimal digit.
  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 8'hC0;
      4'd1:    glyph = 8'hF9;
      4'd2:    glyph = 8'hA4;
      4'd3:    glyph = 8'hB0;
      4'd4:    glyph = 8'h99;
      4'd5:    glyph = 8'h92;
      4'd6:    glyph = 8'h82;
      4'd7:    glyph = 8'hF8;
      4'd8:    glyph = 8'h80;
      4'd9:    glyph = 8'h90;
      default: glyph = SEG_BLANK;
    endcase
  endfunction

  // Encoder: position of the (last) set bit plus a saturating population count.
  always_comb begin
    enc_idx = '0;
    enc_cnt = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      if (in_q[k]) begin
        enc_idx = IDX_W'(k);
        if (enc_cnt != 2'd2) enc_cnt = enc_cnt + 2'd1;
      end
    end
  end

  assign enc_onehot = (enc_cnt == 2'd1);

  // Decimal split by compare-and-subtract; a 5-bit index never exceeds 31.
  always_comb begin
    if (idx_q >= IDX_W'(30)) begin
      tens = 4'd3;
      ones = 4'(idx_q - IDX_W'(30));
    end else if (idx_q >= IDX_W'(20)) begin
      tens = 4'd2;
      ones = 4'(idx_q - IDX_W'(20));
    end else if (idx_q >= IDX_W'(10)) begin
      tens = 4'd1;
      ones = 4'(idx_q - IDX_W'(10));
    end else begin
      tens = 4'd0;
      ones = 4'(idx_q);
    end
  end

  // Next display word for the digit currently selected by the pointer.
  always_comb begin
    en_d      = '1;
    en_d[ptr] = 1'b0;
    seg_d     = SEG_BLANK;
    if (ptr == PTR_W'(0)) begin
      seg_d = valid_q ? glyph(ones) : SEG_DASH;
    end else if (ptr == PTR_W'(1)) begin
      if (!valid_q)            seg_d = SEG_DASH;
      else if (tens != 4'd0)   seg_d = glyph(tens);
    end else if (ptr == PTR_W'(DIGITS - 1)) begin
      seg_d = err_q ? SEG_DP : SEG_BLANK;
    end
  end

  // Two-stage decode pipeline: capture, then encode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_q    <= '0;
      in_vld  <= 1'b0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      in_q   <= bus.onehot_in;
      in_vld <= 1'b1;
      if (in_vld) begin
        if (enc_onehot) begin
          idx_q   <= enc_idx;
          valid_q <= 1'b1;
        end else begin
          valid_q <= 1'b0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  // Scan timing: slot counter and digit pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      ptr      <= '0;
    end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      ptr      <= (ptr == PTR_W'(DIGITS - 1)) ? '0 : ptr + PTR_W'(1);
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

  // Enables and segments share one edge so a slot never tears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q  <= '1;
      seg_q <= SEG_BLANK;
    end else begin
      en_q  <= en_d;
      seg_q <= seg_d;
    end
  end

  assign bus.idx_out    = idx_q;
  assign bus.idx_valid  = valid_q;
  assign bus.err_sticky = err_q;
  assign bus.led_en     = en_q;
  assign bus.led_seg    = seg_q;

endmodule

// File: tb/tb_onehot_led_display.sv
// Self-checking bench for onehot_led_display with a fast scan (SCAN_DIV=4):
// directed reset/walking-one/invalid/scan/async-reset steps plus random
// vectors, all compared every cycle against a behavioural model.
module tb_onehot_led_display;

  localparam int unsigned WIDTH    = 21;
  localparam int unsigned DIGITS   = 8;
  localparam int unsigned SCAN_DIV = 4;

  localparam logic [7:0] GLY [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic clk;
  logic rst;

  onehot_led_display_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  onehot_led_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors;
  int unsigned miscompares;

  // Behavioural model state: sample stage, decoded stage, edges since release.
  logic [WIDTH-1:0] m_inq;
  bit               m_inq_vld;
  int unsigned      m_idx;
  bit               m_valid;
  bit               m_err;
  int unsigned      m_n;
  logic [7:0]       last_seg [DIGITS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_onehot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [7:0] model_seg(input int unsigned d, input int unsigned idx,
                                           input bit v, input bit e);
    if (d == 0)          return v ? GLY[idx % 10] : 8'hBF;
    if (d == 1)          return !v ? 8'hBF : ((idx / 10) == 0 ? 8'hFF : GLY[idx / 10]);
    if (d == DIGITS - 1) return e ? 8'h7F : 8'hFF;
    return 8'hFF;
  endfunction

  task automatic model_reset();
    m_inq     = '0;
    m_inq_vld = 1'b0;
    m_idx     = 0;
    m_valid   = 1'b0;
    m_err     = 1'b0;
    m_n       = 0;
    for (int d = 0; d < DIGITS; d++) last_seg[d] = 8'h00;
  endtask

  // One clock: advance the model across the edge, then compare all outputs.
  task automatic tick();
    int unsigned d;
    logic [7:0] exp_en;
    logic [7:0] exp_seg;
    @(posedge clk);
    m_n++;
    d       = ((m_n - 1) / SCAN_DIV) % DIGITS;
    exp_en  = ~(8'd1 << d);
    exp_seg = model_seg(d, m_idx, m_valid, m_err);
    if (m_inq_vld) begin
      if (is_onehot(m_inq)) begin
        m_idx   = $clog2(m_inq);
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
        m_err   = 1'b1;
      end
    end
    m_inq     = bus.onehot_in;
    m_inq_vld = 1'b1;
    #1;
    check("led_en",     32'(bus.led_en),     32'(exp_en));
    check("led_seg",    32'(bus.led_seg),    32'(exp_seg));
    check("idx_out",    32'(bus.idx_out),    32'(m_idx));
    check("idx_valid",  32'(bus.idx_valid),  32'(m_valid));
    check("err_sticky", 32'(bus.err_sticky), 32'(m_err));
    last_seg[d] = bus.led_seg;
  endtask

  task automatic hold(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  initial begin
    int unsigned sel;
    int unsigned a;
    int unsigned b;
    bit found;
    logic [WIDTH-1:0] v;

    vectors     = 0;
    miscompares = 0;
    model_reset();

    // Reset sampling.
    rst = 1'b0;
    bus.onehot_in = WIDTH'(1);
    repeat (3) @(posedge clk);
    #2;
    check("rst_led_en",    32'(bus.led_en),    32'hFF);
    check("rst_led_seg",   32'(bus.led_seg),   32'hFF);
    check("rst_idx_valid", 32'(bus.idx_valid), 32'h0);
    check("rst_idx_out",   32'(bus.idx_out),   32'h0);
    rst = 1'b1;
    tick();
    check("first_en",  32'(bus.led_en),  32'hFE);
    check("first_seg", 32'(bus.led_seg), 32'hBF);

    // Walking one across every step.
    for (int k = 0; k < WIDTH; k++) begin
      bus.onehot_in = WIDTH'(1) << k;
      hold(3);
    end

    // Step 13 and step 20 over a full scan.
    bus.onehot_in = WIDTH'(1) << 13;
    hold(40);
    check("k13_d0", 32'(last_seg[0]), 32'hB0);
    check("k13_d1", 32'(last_seg[1]), 32'hF9);
    bus.onehot_in = WIDTH'(1) << 20;
    hold(40);
    check("k20_d0", 32'(last_seg[0]), 32'hC0);
    check("k20_d1", 32'(last_seg[1]), 32'hA4);

    // Leading-zero suppression.
    bus.onehot_in = WIDTH'(1) << 7;
    hold(40);
    check("k7_d0", 32'(last_seg[0]), 32'hF8);
    for (int d = 1; d < DIGITS; d++) check("k7_blank", 32'(last_seg[d]), 32'hFF);

    // Invalid vectors: zero, then two bits.
    bus.onehot_in = '0;
    hold(40);
    check("zero_idx",   32'(bus.idx_out),    32'd7);
    check("zero_err",   32'(bus.err_sticky), 32'h1);
    check("zero_d0",    32'(last_seg[0]),    32'hBF);
    check("zero_d1",    32'(last_seg[1]),    32'hBF);
    check("zero_d7",    32'(last_seg[7]),    32'h7F);
    bus.onehot_in = WIDTH'(3);
    hold(40);
    check("two_valid",  32'(bus.idx_valid),  32'h0);
    check("two_idx",    32'(bus.idx_out),    32'd7);
    bus.onehot_in = WIDTH'(1) << 5;
    hold(4);
    check("restore_valid", 32'(bus.idx_valid),  32'h1);
    check("restore_err",   32'(bus.err_sticky), 32'h1);

    // Randomized vectors: one-hot, zero, two-bit, and arbitrary patterns.
    for (int it = 0; it < 80; it++) begin
      sel = $urandom_range(0, 9);
      a   = $urandom_range(0, WIDTH - 1);
      b   = (a + $urandom_range(1, WIDTH - 1)) % WIDTH;
      if (sel < 6)       v = WIDTH'(1) << a;
      else if (sel == 6) v = '0;
      else if (sel == 7) v = (WIDTH'(1) << a) | (WIDTH'(1) << b);
      else               v = WIDTH'($urandom);
      bus.onehot_in = v;
      hold($urandom_range(1, 6));
    end

    // Async reset mid-scan while digit 4 is enabled.
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (bus.led_en == 8'hEF) found = 1'b1;
      else tick();
    end
    check("reach_EF", 32'(found), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_en",    32'(bus.led_en),     32'hFF);
    check("arst_seg",   32'(bus.led_seg),    32'hFF);
    check("arst_valid", 32'(bus.idx_valid),  32'h0);
    check("arst_err",   32'(bus.err_sticky), 32'h0);
    model_reset();
    bus.onehot_in = WIDTH'(1) << 11;
    @(posedge clk);
    #2;
    rst = 1'b1;
    tick();
    check("rel_en",  32'(bus.led_en),     32'hFE);
    check("rel_err", 32'(bus.err_sticky), 32'h0);
    hold(40);
    check("rel_d0", 32'(last_seg[0]), 32'hF9);
    check("rel_d1", 32'(last_seg[1]), 32'hF9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
